// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter/normalizer datapath: default widths,
// normalize-mode encodings and the normalizer FSM states.
package shifter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SHW   = $clog2(DEF_WIDTH);

  localparam logic [1:0] MODE_CLZ = 2'b00;
  localparam logic [1:0] MODE_CTZ = 2'b01;
  localparam logic [1:0] MODE_CLS = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/normalize_stage.sv
// One binary-search stage of the normalizer: tests a 2^k-bit window and
// justifies the value by 2^k when the window is redundant. Purely combinational.
module normalize_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [SHW-1:0]   k_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             take_o
);

  logic [SHW:0]     sh;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] hi_mask;
  logic [WIDTH-1:0] lo_mask;
  logic [WIDTH-1:0] sgn_mask;

  assign ones     = '1;
  assign sh       = (SHW+1)'(1) << k_i;
  assign hi_mask  = ~(ones >> sh);
  assign lo_mask  = ~(ones << sh);
  // Sign mode looks one bit wider: the window must also match the bit above it.
  assign sgn_mask = ~(ones >> (sh + 1'b1));

  always_comb begin
    take_o = 1'b0;
    next_o = value_i;
    case (mode_i)
      MODE_CTZ: begin
        take_o = (value_i & lo_mask) == '0;
        if (take_o) next_o = value_i >> sh;
      end
      MODE_CLS: begin
        take_o = ((value_i & sgn_mask) == '0) || ((value_i & sgn_mask) == sgn_mask);
        if (take_o) next_o = value_i << sh;
      end
      default: begin
        take_o = (value_i & hi_mask) == '0;
        if (take_o) next_o = value_i << sh;
      end
    endcase
  end

endmodule

// File: rtl/normalizer_seq.sv
// Sequential normalizer: finds the justifying shift (CLZ/CTZ/CLS) one search stage per cycle.
// start accepted in IDLE/DONE; busy for SHW cycles, then a one-cycle done with results held.
module normalizer_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic [SHW-1:0]   shamt,
  output logic             allsame,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [1:0]       mode_q;
  logic [SHW-1:0]   step_q;
  logic [SHW-1:0]   acc_q;
  logic [WIDTH-1:0] out_q;
  logic [SHW-1:0]   shamt_q;
  logic             allsame_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] work_d;
  logic             take;
  logic [SHW-1:0]   acc_d;
  logic             allsame_d;

  normalize_stage #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_stage (
    .value_i(work_q),
    .k_i    (step_q),
    .mode_i (mode_q),
    .next_o (work_d),
    .take_o (take)
  );

  assign acc_d = acc_q | (SHW'(take) << step_q);
  // A full shift count means the operand was uniform; in zero-based modes the
  // residue must also be zero to tell an all-zero operand from a lone LSB/MSB.
  assign allsame_d = (&acc_d) && ((mode_q == MODE_CLS) || (work_d == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      mode_q    <= MODE_CLZ;
      step_q    <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      shamt_q   <= '0;
      allsame_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SHIFT: begin
          work_q <= work_d;
          acc_q  <= acc_d;
          if (step_q == '0) begin
            out_q     <= work_d;
            shamt_q   <= acc_d;
            allsame_q <= allsame_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            step_q <= step_q - 1'b1;
          end
        end
        default: begin
          if (start) begin
            work_q  <= A;
            mode_q  <= mode;
            step_q  <= SHW'(SHW - 1);
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign out     = out_q;
  assign shamt   = shamt_q;
  assign allsame = allsame_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_normalizer_seq.sv
// Bench for normalizer_seq: counting-based reference model, per-cycle output
// checker driven by a queue of accepted requests, directed and random stimulus.
module tb_normalizer_seq;
  import shifter_pkg::*;

  typedef struct packed {
    logic [31:0] out;
    logic [4:0]  shamt;
    logic        allsame;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  m;
    int          t;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [1:0]  mode = '0;
  logic [31:0] out;
  logic [4:0]  shamt;
  logic        allsame;
  logic        busy;
  logic        done;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  op_t  q[$];
  res_t cur_exp = '0;
  bit   armed = 1'b0;

  normalizer_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .mode   (mode),
    .out    (out),
    .shamt  (shamt),
    .allsame(allsame),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Reference: count the redundant leading/trailing bits directly.
  function automatic res_t model(input logic [31:0] a, input logic [1:0] m);
    res_t r;
    int   n;
    r = '0;
    n = 0;
    if (m == 2'b01) begin
      if (a == 32'h0) return {32'h0, 5'd31, 1'b1};
      while (a[n] == 1'b0) n++;
      r.out   = a >> n;
      r.shamt = 5'(n);
    end else if (m == 2'b10) begin
      while (n < 31 && a[30-n] == a[31]) n++;
      r.out     = a << n;
      r.shamt   = 5'(n);
      r.allsame = (n == 31);
    end else begin
      if (a == 32'h0) return {32'h0, 5'd31, 1'b1};
      while (a[31-n] == 1'b0) n++;
      r.out   = a << n;
      r.shamt = 5'(n);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_dut(input string name, input res_t exp);
    chk(name, {out, shamt, allsame}, exp);
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      q.delete();
      cur_exp = '0;
      armed   = 1'b1;
    end
  end

  // Per-cycle checker: request accepted at edge t is busy after edges t..t+4, done after t+5.
  always @(negedge clk) begin
    bit eb;
    bit ed;
    eb = 1'b0;
    ed = 1'b0;
    if (armed) begin
      if (q.size() > 0) begin
        if (cyc == q[0].t + 5) ed = 1'b1;
        else if (cyc >= q[0].t) eb = 1'b1;
      end
      chk("busy", busy, eb);
      chk("done", done, ed);
      if (ed) begin
        cur_exp = model(q[0].a, q[0].m);
        void'(q.pop_front());
      end
      chk("out", out, cur_exp.out);
      chk("shamt", shamt, cur_exp.shamt);
      chk("allsame", allsame, cur_exp.allsame);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] m, output int t);
    op_t o;
    A     = a;
    mode  = m;
    start = 1'b1;
    t     = cyc + 1;
    o.a = a;
    o.m = m;
    o.t = t;
    q.push_back(o);
    step();
    start = 1'b0;
    A     = $urandom;
    mode  = 2'($urandom_range(0, 3));
  endtask

  // Advance to the DONE cycle of the request accepted at edge t.
  task automatic wait_done(input int t);
    while (cyc < t + 5) step();
  endtask

  initial begin
    int t;
    int t2;

    chk("model clz", model(32'h00010000, 2'b00), {32'h80000000, 5'd15, 1'b0});
    chk("model ctz", model(32'h00000F00, 2'b01), {32'h0000000F, 5'd8, 1'b0});
    chk("model cls", model(32'hFFFF8000, 2'b10), {32'h80000000, 5'd16, 1'b0});
    chk("model cls ones", model(32'hFFFFFFFF, 2'b10), {32'h80000000, 5'd31, 1'b1});
    chk("model zero m3", model(32'h0, 2'b11), {32'h0, 5'd31, 1'b1});

    repeat (3) @(posedge clk);
    #1;
    chk_dut("reset outputs", '0);
    chk("reset busy", {busy, done}, 2'b00);
    rst_n = 1'b1;
    step();

    issue(32'h00010000, 2'b00, t);
    wait_done(t);
    chk_dut("dir clz", {32'h80000000, 5'd15, 1'b0});
    step();
    issue(32'h00000F00, 2'b01, t);
    wait_done(t);
    chk_dut("dir ctz", {32'h0000000F, 5'd8, 1'b0});
    issue(32'hFFFF8000, 2'b10, t);
    wait_done(t);
    chk_dut("dir cls", {32'h80000000, 5'd16, 1'b0});
    issue(32'hFFFFFFFF, 2'b10, t);
    wait_done(t);
    chk_dut("dir cls ones", {32'h80000000, 5'd31, 1'b1});
    issue(32'h00000000, 2'b10, t);
    wait_done(t);
    chk_dut("dir cls zero", {32'h0, 5'd31, 1'b1});
    issue(32'h00000000, 2'b00, t);
    wait_done(t);
    chk_dut("dir zero m0", {32'h0, 5'd31, 1'b1});
    issue(32'h00000000, 2'b11, t);
    wait_done(t);
    chk_dut("dir zero m3", {32'h0, 5'd31, 1'b1});
    step();

    // Start while busy must be ignored; back-to-back start in DONE accepted.
    issue(32'h00000001, 2'b00, t);
    step();
    A     = 32'h00000002;
    mode  = 2'b00;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(t);
    chk_dut("busy start ignored", {32'h80000000, 5'd31, 1'b0});
    issue(32'h40000000, 2'b00, t2);
    chk("b2b accept edge", t2, t + 6);
    wait_done(t2);
    chk_dut("b2b result", {32'h80000000, 5'd1, 1'b0});
    step();

    // Reset in the middle of a search.
    issue(32'h00F00000, 2'b00, t);
    step();
    step();
    rst_n = 1'b0;
    step();
    chk_dut("abort outputs", '0);
    chk("abort busy", {busy, done}, 2'b00);
    step();
    rst_n = 1'b1;
    step();
    issue(32'h00F00000, 2'b00, t);
    wait_done(t);
    chk_dut("after abort", {32'hF0000000, 5'd8, 1'b0});

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [1:0]  m;
      m = 2'($urandom_range(0, 3));
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) a = ~a;
      if ($urandom_range(0, 15) == 0) a = 32'h0;
      if ($urandom_range(0, 3) == 0) a = a << $urandom_range(0, 31);
      issue(a, m, t);
      wait_done(t);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
    end

    repeat (8) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/normalizer_seq.md
Name: normalizer_seq

Overview:
Multi-cycle normalizer that inverts the barrel-shift operation. Given an operand, it finds the shift amount that left-justifies the operand (or right-justifies it, or strips redundant sign bits) and returns both the justified value and that amount. Shifting the result back by the amount with the existing shifter recovers the operand. It sits beside the shifter in the ALU datapath and serves count-leading/trailing-zero and FP-style normalize operations. It uses a one-stage-per-cycle binary search with a start/busy/done handshake.

Parameters:
WIDTH, 32, operand width; must be a power of two.
SHW, $clog2(WIDTH) = 5, width of the shift amount and number of search stages.

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
A  input  WIDTH  operand; sampled when start is accepted
mode  input  2  00 = CLZ/normalize left; 01 = CTZ/normalize right; 10 = CLS (redundant sign bits), normalize left; 11 = treated as 00
out  output  WIDTH  justified result; held until next completion
shamt  output  SHW  shift amount found; held with out
allsame  output  1  1 if operand is all zeros (modes 00, 01, 11) or all copies of A[31] (mode 10)
busy  output  1  high while searching
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n=0 at an edge):
  - state = IDLE; out = 0, shamt = 0, allsame = 0, busy = 0, done = 0; work registers cleared.
  - Reset mid-search aborts the search: no done pulse, outputs = 0.
- States: IDLE, SHIFT, DONE.
  - IDLE: start=1 → load work value from A, latch mode, step = SHW-1, acc = 0 → SHIFT.
  - SHIFT: busy = 1; one stage per cycle, k = step.
  - Mode 00: if the top 2^k bits of the work value are 0 → shift left by 2^k, set acc[k].
  - Mode 01: if the bottom 2^k bits are 0 → shift right logical by 2^k, set acc[k].
  - Mode 10: if the top 2^k+1 bits all equal the bit above them → shift left by 2^k (zero fill), set acc[k].
  - step 0 done → copy work to out, acc to shamt, compute allsame → DONE.
  - DONE: done = 1 for exactly this cycle. start=1 here is accepted as in IDLE (back-to-back); otherwise → IDLE.
- Latency: start accepted at edge t; busy high for cycles t+1..t+5; done high in cycle t+6. Throughput is one op per 6 cycles.
- start while busy is ignored; A and mode are don't-care after the accepting edge.
- out, shamt and allsame change only on the SHIFT→DONE transition or on reset. Intermediate values are never visible.
- Zero operand (modes 00/01): all stages fire → shamt = 31, out = 0, allsame = 1.
- Mode 10 on 0x00000000 or 0xFFFFFFFF: shamt = 31, allsame = 1.
- Mode 10 invariant: after completion, out[31] != out[30] unless allsame = 1.
- done and busy are never high in the same cycle.

Decomposition:
- Shared package shifter_pkg:
  - mode encodings MODE_CLZ = 2'b00, MODE_CTZ = 2'b01, MODE_CLS = 2'b10.
  - state enum {IDLE, SHIFT, DONE}.
  - WIDTH/SHW defaults.
- Sub-module normalize_stage: purely combinational, inputs (value, k, mode), outputs (next value, take bit). The FSM instantiates it once and iterates k. The FSM, counters and result registers live in normalizer_seq.

Test Plan:
- Reset, then A=0x00010000, mode=00, start at t → done in cycle t+6 only; out=0x80000000, shamt=15, allsame=0; busy high exactly t+1..t+5.
- A=0x00000F00, mode=01 → out=0x0000000F, shamt=8, allsame=0.
- A=0xFFFF8000, mode=10 → out=0x80000000, shamt=16. A=0xFFFFFFFF, mode=10 → out=0x80000000, shamt=31, allsame=1.
- A=0x00000000, mode=00 → out=0, shamt=31, allsame=1. Same operand with mode=11 gives identical results.
- start=1 with A=0x1 at t; start=1 with A=0x2 at t+2 → second request ignored; result shamt=31, out=0x80000000. A new start in the DONE cycle (t+6) with A=0x40000000, mode=00 → done at t+12, shamt=1. The first result stays on the outputs until then.
- start at t, rst_n=0 at t+3 → from t+4: busy=0, out=0, shamt=0, and done never asserts. After release, an idle start resumes normal 6-cycle operation.
